// File: rtl/odt_console_bridge.sv
// odt_console_bridge: DLART console RBUF/XBUF <-> 8-bit Apple II host strobe port.
// TX FIFO buffers CPU XBUF writes until the host takes them with an rrdy/rstb
// handshake; RX FIFO buffers host bytes delivered with a wrdy/wstb handshake
// until the CPU reads RBUF. rrdy/wrdy are asynchronous and are synchronised
// before any use.
module odt_console_bridge #(
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_init,
  input  logic       xbuf_wr,
  input  logic [7:0] xbuf_data,
  input  logic       rbuf_rd,
  output logic [7:0] rbuf_data,
  output logic       rcsr_done,
  output logic       xcsr_ready,
  output logic       tx_overflow,
  input  logic       rrdy,
  output logic       rstb,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic       wrdy,
  output logic       wstb,
  input  logic [7:0] ad_in
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [TAW-1:0] TPTR_ONE  = TAW'(1);
  localparam logic [TAW:0]   TCNT_ONE  = (TAW+1)'(1);
  localparam logic [TAW:0]   TCNT_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW-1:0] RPTR_ONE  = RAW'(1);
  localparam logic [RAW:0]   RCNT_ONE  = (RAW+1)'(1);
  localparam logic [RAW:0]   RCNT_FULL = (RAW+1)'(RX_DEPTH);

  typedef enum logic { T_IDLE = 1'b0, T_STB = 1'b1 } tx_state_e;
  typedef enum logic { R_IDLE = 1'b0, R_STB = 1'b1 } rx_state_e;

  // ---------------------------------------------------------------------------
  // Host handshake synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rrdy_sync_q, wrdy_sync_q;
  logic                   rrdy_s, wrdy_s;

  // shift the async ready lines through the synchroniser chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrdy_sync_q <= '0;
      wrdy_sync_q <= '0;
    end else begin
      rrdy_sync_q <= {rrdy_sync_q[SYNC_STAGES-2:0], rrdy};
      wrdy_sync_q <= {wrdy_sync_q[SYNC_STAGES-2:0], wrdy};
    end
  end

  assign rrdy_s = rrdy_sync_q[SYNC_STAGES-1];
  assign wrdy_s = wrdy_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // TX FIFO (CPU -> host)
  // ---------------------------------------------------------------------------
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TAW:0]   tx_cnt_q;
  logic           tx_full, tx_empty, tx_push, tx_pop;
  logic           tx_overflow_q;
  tx_state_e      tx_state_q, tx_state_d;
  logic           tx_load;
  logic [7:0]     ad_out_q;

  assign tx_full  = (tx_cnt_q == TCNT_FULL);
  assign tx_empty = (tx_cnt_q == '0);
  // The host releasing rrdy while strobed retires the head byte.
  assign tx_pop   = (tx_state_q == T_STB) && !rrdy_s;
  // A same-clock pop frees the slot, so a write to a full FIFO still lands.
  assign tx_push  = xbuf_wr && (!tx_full || tx_pop);

  // TX storage: no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (tx_push && !bus_init) tx_mem_q[tx_wptr_q] <= xbuf_data;
  end

  // TX pointers, occupancy count and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_cnt_q      <= '0;
      tx_overflow_q <= 1'b0;
    end else if (bus_init) begin
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_cnt_q      <= '0;
      tx_overflow_q <= 1'b0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + TPTR_ONE;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TPTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + TCNT_ONE;
        2'b01:   tx_cnt_q <= tx_cnt_q - TCNT_ONE;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
      if (xbuf_wr && !tx_push) tx_overflow_q <= 1'b1;
    end
  end

  // TX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_q <= T_IDLE;
    else        tx_state_q <= tx_state_d;
  end

  // TX FSM next state: strobe a byte out only on a fresh rrdy_s=1
  always_comb begin
    tx_state_d = tx_state_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty && rrdy_s) begin
          tx_state_d = T_STB;
          tx_load    = 1'b1;
        end
      end
      T_STB: begin
        if (!rrdy_s) tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
    if (bus_init) begin
      tx_state_d = T_IDLE;
      tx_load    = 1'b0;
    end
  end

  // ad_out latches the head byte as the strobe is raised and holds through it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ad_out_q <= '0;
    else if (bus_init) ad_out_q <= '0;
    else if (tx_load)  ad_out_q <= tx_mem_q[tx_rptr_q];
  end

  assign rstb        = (tx_state_q == T_STB);
  assign ad_oe       = rstb;
  assign ad_out      = ad_out_q;
  assign xcsr_ready  = !tx_full;
  assign tx_overflow = tx_overflow_q;

  // ---------------------------------------------------------------------------
  // RX FIFO (host -> CPU)
  // ---------------------------------------------------------------------------
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wptr_q, rx_rptr_q, rx_rptr_nx;
  logic [RAW:0]   rx_cnt_q;
  logic           rx_full, rx_empty, rx_push, rx_pop;
  rx_state_e      rx_state_q, rx_state_d;
  logic [7:0]     rbuf_data_q, rbuf_data_d;

  assign rx_full    = (rx_cnt_q == RCNT_FULL);
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_rptr_nx = rx_rptr_q + RPTR_ONE;
  // R_STB is only entered with a free slot and only R_STB pushes, so this
  // push can never meet a full FIFO.
  assign rx_push    = (rx_state_q == R_STB) && !wrdy_s;
  assign rx_pop     = rbuf_rd && !rx_empty;

  // RX storage: ad_in captured on the clock the host drops wrdy_s
  always_ff @(posedge clk) begin
    if (rx_push && !bus_init) rx_mem_q[rx_wptr_q] <= ad_in;
  end

  // RX pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else if (bus_init) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + RPTR_ONE;
      if (rx_pop)  rx_rptr_q <= rx_rptr_nx;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + RCNT_ONE;
        2'b01:   rx_cnt_q <= rx_cnt_q - RCNT_ONE;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  // RBUF head register: track the byte that will be at the head next clock.
  // A push into an empty (or emptying) FIFO becomes the head directly;
  // otherwise a pop exposes the next stored byte. Reads of an empty FIFO hold.
  always_comb begin
    rbuf_data_d = rbuf_data_q;
    if (rx_push && (rx_empty || (rx_cnt_q == RCNT_ONE && rx_pop)))
      rbuf_data_d = ad_in;
    else if (rx_pop && rx_cnt_q > RCNT_ONE)
      rbuf_data_d = rx_mem_q[rx_rptr_nx];
  end

  // RBUF head register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rbuf_data_q <= '0;
    else if (!bus_init) rbuf_data_q <= rbuf_data_d;
  end

  // RX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_q <= R_IDLE;
    else        rx_state_q <= rx_state_d;
  end

  // RX FSM next state: ack the host only when a slot is free (back-pressure)
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_IDLE:  if (wrdy_s && !rx_full) rx_state_d = R_STB;
      R_STB:   if (!wrdy_s) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
    if (bus_init) rx_state_d = R_IDLE;
  end

  assign wstb      = (rx_state_q == R_STB);
  assign rbuf_data = rbuf_data_q;
  assign rcsr_done = !rx_empty;

endmodule
